// File: rtl/project_switch_poller.sv
// Avalon-MM read master that polls one PIO register at a fixed interval.
// Publishes the captured value with change detection and a sticky interrupt.
module project_switch_poller #(
  parameter int POLL_INTERVAL = 1000,
  parameter int READ_LATENCY  = 1,
  parameter int ADDR_W        = 2,
  parameter int DATA_W        = 32,
  parameter int SRC_ADDR      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              changed,
  output logic              irq,
  input  logic              irq_clear
);

  localparam int                CNT_W         = $clog2(POLL_INTERVAL + 1);
  localparam logic [CNT_W-1:0]  INTERVAL_LOAD = CNT_W'(POLL_INTERVAL - 1);
  localparam logic [1:0]        LAT_LOAD      = 2'(READ_LATENCY - 1);
  localparam logic [ADDR_W-1:0] SRC_ADDR_V    = ADDR_W'(SRC_ADDR);

  typedef enum logic [1:0] {IDLE, REQ, LAT, CAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] interval_cnt;
  logic [1:0]       lat_cnt;
  logic             primed;
  logic             capture;
  logic             change_hit;

  // The slave only ever sees one register address.
  assign avm_address = SRC_ADDR_V;

  assign capture    = (state == LAT) && (lat_cnt == 2'd0);
  assign change_hit = capture && primed && (avm_readdata != sample);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      interval_cnt <= INTERVAL_LOAD;
      lat_cnt      <= 2'd0;
      primed       <= 1'b0;
      avm_read     <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      changed      <= 1'b0;
      irq          <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all outputs move together on one edge.
      sample_valid <= capture;
      changed      <= change_hit;

      // Set wins over a simultaneous clear.
      if (change_hit)     irq <= 1'b1;
      else if (irq_clear) irq <= 1'b0;

      if (capture) begin
        sample <= avm_readdata;
        primed <= 1'b1;
      end

      unique case (state)
        // CAP counts as the first idle cycle of the interval.
        IDLE, CAP: begin
          if (!enable) begin
            state        <= IDLE;
            interval_cnt <= INTERVAL_LOAD;
          end else if (!primed || interval_cnt == '0) begin
            // NOTE: primed is clear only before the first read since reset, so it also marks the interval skip.
            state    <= REQ;
            avm_read <= 1'b1;
          end else begin
            state        <= IDLE;
            interval_cnt <= interval_cnt - 1'b1;
          end
        end
        REQ: begin
          if (!avm_waitrequest) begin
            state    <= LAT;
            avm_read <= 1'b0;
            lat_cnt  <= LAT_LOAD;
          end
        end
        LAT: begin
          if (lat_cnt == 2'd0) begin
            state        <= CAP;
            interval_cnt <= INTERVAL_LOAD;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_project_switch_poller.sv
// Directed bench for project_switch_poller: table of polls plus hand sequences
// for enable drop and reset during the latency phase.
module tb_project_switch_poller;

  localparam int P   = 10;
  localparam int L   = 3;
  localparam int SRC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        waitreq;
  logic        irq_clear;
  logic [31:0] readdata;

  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] sample;
  logic        sample_valid;
  logic        changed;
  logic        irq;

  logic [1:0]  l1_address;
  logic        l1_read;
  logic [31:0] l1_sample;
  logic        l1_sample_valid;
  logic        l1_changed;
  logic        l1_irq;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  project_switch_poller #(
    .POLL_INTERVAL(P), .READ_LATENCY(L), .ADDR_W(2), .DATA_W(32), .SRC_ADDR(SRC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(waitreq), .avm_readdata(readdata),
    .sample(sample), .sample_valid(sample_valid), .changed(changed),
    .irq(irq), .irq_clear(irq_clear)
  );

  project_switch_poller #(
    .POLL_INTERVAL(P), .READ_LATENCY(1), .ADDR_W(2), .DATA_W(32), .SRC_ADDR(0)
  ) dut_l1 (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(l1_address), .avm_read(l1_read),
    .avm_waitrequest(waitreq), .avm_readdata(readdata),
    .sample(l1_sample), .sample_valid(l1_sample_valid), .changed(l1_changed),
    .irq(l1_irq), .irq_clear(irq_clear)
  );

  typedef struct {
    logic [31:0] rd;
    bit          clr_before;
    bit          clr_hold;
    int          wait_n;
    bit          exp_changed;
    bit          exp_irq;
  } poll_vec_t;

  poll_vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic wait_read(output int t);
    int n = 0;
    while (avm_read !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    if (avm_read !== 1'b1) check("read_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(output int t);
    int n = 0;
    while (sample_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    if (sample_valid !== 1'b1) check("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tr, tc, t0, prev_tr, prev_w, reads;

    vecs[0] = '{32'h3,         1'b0, 1'b0, 0, 1'b1, 1'b1};
    vecs[1] = '{32'h3,         1'b1, 1'b0, 4, 1'b0, 1'b0};
    vecs[2] = '{32'h6,         1'b0, 1'b0, 0, 1'b1, 1'b1};
    vecs[3] = '{32'h6,         1'b0, 1'b0, 0, 1'b0, 1'b1};
    vecs[4] = '{32'h2,         1'b0, 1'b1, 2, 1'b1, 1'b1};
    vecs[5] = '{32'h8000_0002, 1'b1, 1'b0, 0, 1'b1, 1'b1};
    vecs[6] = '{32'h8000_0002, 1'b1, 1'b0, 0, 1'b0, 1'b0};

    reset = 1'b1; enable = 1'b0; waitreq = 1'b0; irq_clear = 1'b0; readdata = 32'h5;
    repeat (2) @(negedge clk);
    check("rst_read",    avm_read,     0);
    check("rst_address", avm_address,  SRC);
    check("rst_sample",  sample,       0);
    check("rst_valid",   sample_valid, 0);
    check("rst_changed", changed,      0);
    check("rst_irq",     irq,          0);
    reset = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("no_read_when_disabled", avm_read, 0);
    end

    // First request skips the interval.
    enable = 1'b1;
    @(negedge clk);
    check("first_req",    avm_read, 1);
    check("first_req_l1", l1_read,  1);
    check("first_addr",   avm_address, SRC);
    tr = cyc;
    for (int k = 1; k <= 1 + L; k++) begin
      @(negedge clk);
      check("l1_valid_timing", l1_sample_valid, (k == 2));
      check("valid_timing",    sample_valid,    (k == 1 + L));
      if (k == 2) begin
        check("l1_first_sample",  l1_sample,  32'h5);
        check("l1_first_changed", l1_changed, 0);
        check("l1_first_irq",     l1_irq,     0);
      end
    end
    check("first_sample",  sample,  32'h5);
    check("first_changed", changed, 0);
    check("first_irq",     irq,     0);
    prev_tr = tr;
    prev_w  = 0;

    foreach (vecs[i]) begin
      readdata = vecs[i].rd;
      if (vecs[i].wait_n > 0) waitreq = 1'b1;
      if (vecs[i].clr_before) begin
        irq_clear = 1'b1;
        @(negedge clk);
        irq_clear = 1'b0;
        check("irq_clear", irq, 0);
      end
      if (vecs[i].clr_hold) irq_clear = 1'b1;

      wait_read(tr);
      check("poll_period", 32'(tr - prev_tr), 32'(1 + prev_w + L + P));
      check("req_address", avm_address, SRC);
      for (int k = 1; k <= vecs[i].wait_n; k++) begin
        @(negedge clk);
        check("hold_read", avm_read,    1);
        check("hold_addr", avm_address, SRC);
        if (k == vecs[i].wait_n) waitreq = 1'b0;
      end

      wait_valid(tc);
      check("cap_latency", 32'(tc - tr), 32'(1 + vecs[i].wait_n + L));
      check("sample",  sample,  vecs[i].rd);
      check("changed", changed, vecs[i].exp_changed);
      check("irq",     irq,     vecs[i].exp_irq);
      irq_clear = 1'b0;
      @(negedge clk);
      check("valid_pulse_end",   sample_valid, 0);
      check("changed_pulse_end", changed,      0);
      prev_tr = tr;
      prev_w  = vecs[i].wait_n;
    end

    // Enable dropped during LAT: capture still completes, then polling stops.
    readdata = 32'h9;
    wait_read(tr);
    check("poll_period_pre_drop", 32'(tr - prev_tr), 32'(1 + prev_w + L + P));
    @(negedge clk);
    enable = 1'b0;
    wait_valid(tc);
    check("drop_cap_latency", 32'(tc - tr), 32'(1 + L));
    check("drop_sample",  sample,  32'h9);
    check("drop_changed", changed, 1);
    reads = 0;
    repeat (30) begin
      @(negedge clk);
      if (avm_read === 1'b1) reads++;
    end
    check("no_read_after_drop", reads, 0);
    enable = 1'b1;
    t0 = cyc;
    wait_read(tr);
    check("reenable_gap", 32'(tr - t0), P);

    // Reset during LAT: state cleared at once, next first capture is unprimed.
    wait_valid(tc);
    @(negedge clk);
    readdata = 32'h4;
    check("irq_before_reset", irq, 1);
    wait_read(tr);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_read",    avm_read,     0);
    check("mid_rst_sample",  sample,       0);
    check("mid_rst_irq",     irq,          0);
    check("mid_rst_valid",   sample_valid, 0);
    check("mid_rst_changed", changed,      0);
    @(negedge clk);
    reset = 1'b0;
    t0 = cyc;
    wait_read(tr);
    check("post_rst_req", 32'(tr - t0), 1);
    wait_valid(tc);
    check("post_rst_latency", 32'(tc - tr), 32'(1 + L));
    check("post_rst_sample",  sample,  32'h4);
    check("post_rst_changed", changed, 0);
    check("post_rst_irq",     irq,     0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/project_switch_poller.md
# project_switch_poller

Avalon-MM read master that periodically polls a single-register PIO input slave, such as the 3-bit switch port, and presents the captured value to local logic. It is the initiator end of that slave's read interface: it issues reads, honours waitrequest and fixed read latency, and flags value changes with a one-cycle pulse and a sticky interrupt. It sits between the interconnect and local control logic that needs switch state without a CPU in the loop.

## Interface
- POLL_INTERVAL, 1000: idle cycles between the end of one capture and the next read request (≥1)
- READ_LATENCY, 1: fixed slave read latency in cycles (1–4)
- ADDR_W, 2: address width
- DATA_W, 32: readdata width
- SRC_ADDR, 0: slave register address polled
- clk  in  1  system clock; all logic rising-edge
- reset  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high)
- enable  in  1  polling permitted while high
- avm_address  out  ADDR_W  read address, constant SRC_ADDR while avm_read high
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall; request held while high
- avm_readdata  in  DATA_W  read data, valid READ_LATENCY cycles after acceptance
- sample  out  DATA_W  last captured value
- sample_valid  out  1  one-cycle pulse on each capture
- changed  out  1  one-cycle pulse when capture differs from previous sample
- irq  out  1  sticky change flag
- irq_clear  in  1  clears irq

## Operation
- States: IDLE, REQ, LAT, CAP.
- IDLE: interval counter counts down from POLL_INTERVAL-1; at 0 with enable=1 → REQ. enable=0 holds counter at POLL_INTERVAL-1.
- Exception: the first request after reset release (with enable=1) skips the interval; IDLE → REQ on the first enabled cycle.
- REQ: avm_read=1, avm_address=SRC_ADDR. Stay while avm_waitrequest=1. Accepted on a rising edge where avm_waitrequest=0 → LAT with latency counter = READ_LATENCY-1.
- LAT: counts down; avm_read=0. When counter=0 (the cycle READ_LATENCY cycles after acceptance), avm_readdata is valid → CAP captures on that edge.
- CAP capture edge: sample ← avm_readdata; sample_valid=1 next cycle; changed=1 next cycle if new value ≠ old sample and a prior valid sample exists; irq set if changed. Return to IDLE, counter reloaded.
- First capture after reset never asserts changed or irq (primed flag cleared by reset, set on first capture).
- Deasserting enable in REQ/LAT/CAP does not abort: the transaction completes and is captured; the FSM then waits in IDLE.
- irq: set by change, cleared by irq_clear; simultaneous set and clear → irq stays 1 (set wins).
- Full-width compare; unused upper readdata bits (zero from a 3-bit slave) are compared as-is.
- Widths: interval counter ceil(log2(POLL_INTERVAL+1)) bits, latency counter 2 bits; no wrap beyond load values.

## Timing
- Reset values: avm_read=0, avm_address=SRC_ADDR, sample=0, sample_valid=0, changed=0, irq=0, state IDLE, primed=0.
- Reset asserted mid-transaction: avm_read drops immediately (asynchronous); the in-flight read is discarded; no pulses.
- Poll period with zero waitrequest = 1 (REQ) + READ_LATENCY + POLL_INTERVAL cycles.
- sample, sample_valid, changed, irq all update on the same edge; outputs are registered, none combinational from inputs except through the FSM.
- Only one outstanding read at a time; avm_read is never asserted in LAT/CAP/IDLE.

## Test plan
- Reset then enable=1, readdata=0x5, latency 1, no waitrequest: avm_read high 1 cycle after enable; sample=0x5 with sample_valid pulse 2 cycles after request start; changed=0, irq=0.
- Slave value 0x5 → 0x3 between polls: the next capture gives sample=0x3, changed pulse, irq=1; irq_clear pulse → irq=0; a repeat poll at 0x3 gives no changed.
- waitrequest high 4 cycles on a request: avm_read and avm_address held stable for 5 cycles; capture occurs READ_LATENCY after the fifth cycle.
- POLL_INTERVAL=10, READ_LATENCY=3: consecutive avm_read rising edges are 14 cycles apart; capture happens exactly 3 cycles after acceptance.
- enable dropped during LAT: the capture still occurs, then no further avm_read until enable returns; after re-enable the next request follows a full interval.
- reset asserted during LAT: outputs return to reset values within the same cycle; after release, the first capture does not pulse changed even if the value differs from the pre-reset sample.
